// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: access size codes and FSM states.
// Also hosts the alignment rule used when an access is accepted.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        NONE     = 2'b00,
        BYTE     = 2'b01,
        HALFWORD = 2'b10,
        WORD     = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RMW_RD,
        RMW_WR,
        ERR
    } state_e;

    function automatic logic misaligned(input size_e sz, input logic [1:0] lo);
        return (sz == WORD && lo != 2'b00) || (sz == HALFWORD && lo[0]);
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: merges store data into a memory word and
// extracts/sign-extends load data from one.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  size_e       size_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_o
);

    logic [4:0]  sh;
    logic [31:0] mask;
    logic [31:0] rd_sh;

    assign sh    = {lane_i, 3'b000};
    assign rd_sh = rdata_i >> sh;

    always_comb begin
        mask   = 32'hFFFF_FFFF;
        load_o = rd_sh;
        case (size_i)
            BYTE: begin
                mask   = 32'h0000_00FF << sh;
                load_o = {{24{rd_sh[7]}}, rd_sh[7:0]};
            end
            HALFWORD: begin
                mask   = 32'h0000_FFFF << sh;
                load_o = {{16{rd_sh[15]}}, rd_sh[15:0]};
            end
            default: ;
        endcase
        merged_o = (rdata_i & ~mask) | ((wdata_i << sh) & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with registered memory port and
// read-modify-write handling for sub-word stores.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  ctrl_mem_read_i,
    input  logic [1:0]  ctrl_mem_write_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_data_o,
    output logic        resp_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [7:0]  mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    state_e      state_q, state_d;
    size_e       size_q, size_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] wdata_q, wdata_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [7:0]  mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_data_q, resp_data_d;

    logic        is_st, is_ld;
    size_e       req_sz;
    logic [31:0] merged, load_data;
    logic        unused_addr;

    // Only a 1 KiB window is addressed; upper address bits are ignored.
    assign unused_addr = ^req_addr_i[31:10];

    assign is_st  = ctrl_mem_write_i != 2'(NONE);
    assign is_ld  = ctrl_mem_read_i != 2'(NONE);
    assign req_sz = is_st ? size_e'(ctrl_mem_write_i)
                          : size_e'(ctrl_mem_read_i);

    lsu_align u_align (
        .size_i   (size_q),
        .lane_i   (lane_q),
        .wdata_i  (wdata_q),
        .rdata_i  (mem_rdata_i),
        .merged_o (merged),
        .load_o   (load_data)
    );

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_data_d  = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i && (is_st || is_ld)) begin
                    size_d     = req_sz;
                    lane_d     = req_addr_i[1:0];
                    wdata_d    = req_wdata_i;
                    mem_addr_d = req_addr_i[9:2];
                    if (misaligned(req_sz, req_addr_i[1:0])) begin
                        state_d      = ERR;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (!is_st) begin
                        state_d   = RD;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b0;
                    end else if (req_sz == WORD) begin
                        state_d     = WR;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = req_wdata_i;
                    end else begin
                        state_d   = RMW_RD;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b0;
                    end
                end
            end
            RD: begin
                if (mem_ack_i) begin
                    state_d      = IDLE;
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_data_d  = load_data;
                end
            end
            RMW_RD: begin
                if (mem_ack_i) begin
                    state_d     = RMW_WR;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = merged;
                end
            end
            WR, RMW_WR: begin
                if (mem_ack_i) begin
                    state_d      = IDLE;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                end
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q      <= IDLE;
            size_q       <= NONE;
            lane_q       <= 2'b00;
            wdata_q      <= 32'h0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 8'h0;
            mem_wdata_q  <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign req_ready_o  = state_q == IDLE;
    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign resp_data_o  = resp_data_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory
// that acks after a programmable number of wait cycles.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk_i = 1'b0;
    logic        n_rst_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_addr_i = 32'h0;
    logic [31:0] req_wdata_i = 32'h0;
    logic [1:0]  ctrl_mem_read_i = 2'b00;
    logic [1:0]  ctrl_mem_write_i = 2'b00;
    logic        resp_valid_o;
    logic [31:0] resp_data_o;
    logic        resp_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [7:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;

    load_store_unit dut (
        .clk_i            (clk_i),
        .n_rst_i          (n_rst_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_addr_i       (req_addr_i),
        .req_wdata_i      (req_wdata_i),
        .ctrl_mem_read_i  (ctrl_mem_read_i),
        .ctrl_mem_write_i (ctrl_mem_write_i),
        .resp_valid_o     (resp_valid_o),
        .resp_data_o      (resp_data_o),
        .resp_err_o       (resp_err_o),
        .mem_req_o        (mem_req_o),
        .mem_we_o         (mem_we_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_ack_i        (mem_ack_i),
        .mem_rdata_i      (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
        int          lat;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_resp = 0;
    int          n_ack = 0;
    int          ack_delay = 0;
    int          wcnt = 0;
    logic        hold_wr = 1'b0;
    logic        spur = 1'b0;
    logic [7:0]  last_wa = 8'h0;
    logic [31:0] last_wd = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic m_mis(input logic [1:0] sz, input logic [1:0] lo);
        return (sz == 2'(WORD) && lo != 2'b00) || (sz == 2'(HALFWORD) && lo[0]);
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz,
                                           input logic [1:0] lo,
                                           input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        if (sz == 2'(BYTE)) return {{24{b[7]}}, b};
        if (sz == 2'(HALFWORD)) return {{16{h[15]}}, h};
        return w;
    endfunction

    function automatic logic [31:0] m_store(input logic [1:0] sz,
                                            input logic [1:0] lo,
                                            input logic [31:0] old,
                                            input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        if (sz == 2'(WORD)) r = wd;
        else if (sz == 2'(HALFWORD)) begin
            if (lo[1]) r[31:16] = wd[15:0];
            else       r[15:0]  = wd[15:0];
        end else begin
            case (lo)
                2'd0:    r[7:0]   = wd[7:0];
                2'd1:    r[15:8]  = wd[7:0];
                2'd2:    r[23:16] = wd[7:0];
                default: r[31:24] = wd[7:0];
            endcase
        end
        return r;
    endfunction

    always @(posedge clk_i) cyc <= cyc + 1;

    // Memory responder
    always @(negedge clk_i) begin
        if (spur) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = $urandom;
        end else if (mem_req_o && !(hold_wr && mem_we_o)) begin
            if (wcnt >= ack_delay) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = mem[mem_addr_o];
                if (mem_we_o) begin
                    mem[mem_addr_o] = mem_wdata_o;
                    last_wa = mem_addr_o;
                    last_wd = mem_wdata_o;
                end
                n_ack++;
                wcnt = 0;
            end else begin
                mem_ack_i   = 1'b0;
                mem_rdata_i = $urandom;
                wcnt++;
            end
        end else begin
            mem_ack_i = 1'b0;
            wcnt      = 0;
        end
    end

    // Response monitor
    always @(negedge clk_i) begin
        if (resp_valid_o) begin
            n_resp++;
            if (sb.size() == 0) begin
                chk("unexp_resp", {31'h0, resp_valid_o}, 32'h0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("resp_data", resp_data_o, e.data);
                chk("resp_err", {31'h0, resp_err_o}, {31'h0, e.err});
                chk("resp_lat", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic issue(input logic [1:0] rd, input logic [1:0] wr,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] ed, input logic ee,
                         input int el);
        sb_t e;
        int  t;
        @(negedge clk_i);
        t = 0;
        while (!req_ready_o && t < 100) begin
            @(negedge clk_i);
            t++;
        end
        if (!req_ready_o) begin
            chk("ready_timeout", {31'h0, req_ready_o}, 32'h1);
            return;
        end
        req_valid_i      = 1'b1;
        ctrl_mem_read_i  = rd;
        ctrl_mem_write_i = wr;
        req_addr_i       = addr;
        req_wdata_i      = wd;
        e.data = ed;
        e.err  = ee;
        e.acc  = cyc;
        e.lat  = el;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        req_valid_i      = 1'b0;
        req_addr_i       = $urandom;
        req_wdata_i      = $urandom;
        ctrl_mem_read_i  = 2'($urandom);
        ctrl_mem_write_i = 2'($urandom);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sb.size() != 0 || !req_ready_o) && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        if (sb.size() != 0) chk("idle_timeout", sb.size(), 32'h0);
        @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          snap;
        int          acks;
        int          bad;
        int          d;
        logic [1:0]  sz;
        logic [1:0]  rd;
        logic [31:0] a;
        logic [31:0] wd;
        logic        mis;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[1]     = 32'h8001_7FFF;
        ref_mem[1] = mem[1];

        @(negedge clk_i);
        chk("rst_ready", {31'h0, req_ready_o}, 32'h1);
        chk("rst_req", {31'h0, mem_req_o}, 32'h0);
        chk("rst_we", {31'h0, mem_we_o}, 32'h0);
        chk("rst_resp", {31'h0, resp_valid_o}, 32'h0);
        chk("rst_err", {31'h0, resp_err_o}, 32'h0);
        chk("rst_data", resp_data_o, 32'h0);
        chk("rst_addr", {24'h0, mem_addr_o}, 32'h0);
        chk("rst_wdata", mem_wdata_o, 32'h0);
        @(posedge clk_i);
        #1 n_rst_i = 1'b1;

        // word store, immediate ack
        issue(NONE, WORD, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        ref_mem[4] = 32'hDEADBEEF;
        wait_idle();
        chk("wst_addr", {24'h0, last_wa}, 32'h04);
        chk("wst_data", last_wd, 32'hDEADBEEF);

        // byte store via read-modify-write
        mem[4]     = 32'h1122_3344;
        ref_mem[4] = mem[4];
        issue(NONE, BYTE, 32'h13, 32'h0000_00AB, 32'h0, 1'b0, 3);
        ref_mem[4] = 32'hAB22_3344;
        wait_idle();
        chk("bst_word", mem[4], 32'hAB22_3344);

        // back-to-back sign-extended loads
        issue(HALFWORD, NONE, 32'h06, 32'h0, 32'hFFFF_8001, 1'b0, 2);
        issue(BYTE, NONE, 32'h04, 32'h0, 32'hFFFF_FFFF, 1'b0, 2);
        issue(HALFWORD, NONE, 32'h04, 32'h0, 32'h0000_7FFF, 1'b0, 2);
        wait_idle();

        // misaligned accesses never reach memory
        acks = n_ack;
        issue(WORD, NONE, 32'h02, 32'h0, 32'h0, 1'b1, 1);
        issue(NONE, HALFWORD, 32'h05, 32'h1234, 32'h0, 1'b1, 1);
        wait_idle();
        chk("mis_noreq", n_ack, acks);

        // no load and no store: nothing happens
        snap = n_resp;
        @(negedge clk_i);
        req_valid_i      = 1'b1;
        ctrl_mem_read_i  = NONE;
        ctrl_mem_write_i = NONE;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("noop_resp", n_resp, snap);
        chk("noop_req", {31'h0, mem_req_o}, 32'h0);

        // delayed ack: outputs held, ready low, one response
        ack_delay = 3;
        snap = n_resp;
        issue(WORD, NONE, 32'h20, 32'h0, ref_mem[8], 1'b0, 5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("hold_req", {31'h0, mem_req_o}, 32'h1);
            chk("hold_we", {31'h0, mem_we_o}, 32'h0);
            chk("hold_addr", {24'h0, mem_addr_o}, 32'h08);
            chk("hold_ready", {31'h0, req_ready_o}, 32'h0);
            req_valid_i      = (i < 3);
            req_addr_i       = $urandom;
            ctrl_mem_read_i  = 2'($urandom);
            ctrl_mem_write_i = 2'($urandom);
        end
        wait_idle();
        chk("delay_one_resp", n_resp, snap + 1);

        // random mix with varying wait states
        for (int n = 0; n < 40; n++) begin
            wait_idle();
            d         = $urandom_range(0, 2);
            ack_delay = d;
            sz        = 2'($urandom_range(1, 3));
            a         = $urandom;
            wd        = $urandom;
            mis       = m_mis(sz, a[1:0]);
            if ($urandom_range(0, 1) == 0) begin
                issue(sz, NONE, a, wd,
                      mis ? 32'h0 : m_load(sz, a[1:0], ref_mem[a[9:2]]),
                      mis, mis ? 1 : 2 + d);
            end else begin
                rd = 2'($urandom);
                issue(rd, sz, a, wd, 32'h0, mis,
                      mis ? 1 : (sz == 2'(WORD) ? 2 + d : 3 + 2 * d));
                if (!mis) ref_mem[a[9:2]] = m_store(sz, a[1:0], ref_mem[a[9:2]], wd);
            end
        end
        wait_idle();
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_image", bad, 32'h0);

        // reset asserted while in RMW_WR
        ack_delay = 0;
        hold_wr   = 1'b1;
        issue(NONE, BYTE, 32'h31, 32'h5A, 32'h0, 1'b0, 3);
        for (int t = 0; t < 20 && !mem_we_o; t++) @(negedge clk_i);
        chk("rmw_wr_seen", {31'h0, mem_we_o}, 32'h1);
        #2 n_rst_i = 1'b0;
        #1;
        chk("arst_req", {31'h0, mem_req_o}, 32'h0);
        chk("arst_we", {31'h0, mem_we_o}, 32'h0);
        chk("arst_ready", {31'h0, req_ready_o}, 32'h1);
        chk("arst_wdata", mem_wdata_o, 32'h0);
        sb.delete();
        snap    = n_resp;
        hold_wr = 1'b0;
        spur    = 1'b1;
        @(posedge clk_i);
        #1 n_rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        spur = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("spur_noresp", n_resp, snap);
        chk("spur_noreq", {31'h0, mem_req_o}, 32'h0);
        chk("abandon_word", mem[12], ref_mem[12]);

        // unit works again after reset
        issue(BYTE, NONE, 32'h07, 32'h0, m_load(BYTE, 2'd3, ref_mem[1]), 1'b0, 2);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low; ports clk_i and n_rst_i.
REQ-002 clk_i  in  1  clock; all state updates on posedge.
REQ-003 n_rst_i  in  1  async active-low reset.
REQ-004 req_valid_i  in  1  pipeline presents an access.
REQ-005 req_ready_o  out  1  unit idle, accepts access this cycle.
REQ-006 req_addr_i  in  32  byte address.
REQ-007 req_wdata_i  in  32  store data, right-aligned.
REQ-008 ctrl_mem_read_i  in  2  load size, shared-header codes `WORD`, `HALFWORD`, `BYTE`; other value means no load.
REQ-009 ctrl_mem_write_i  in  2  store size, same codes; a store takes priority if both fields are active.
REQ-010 resp_valid_o  out  1  one-cycle completion pulse.
REQ-011 resp_data_o  out  32  sign-extended load result; 0 for stores and errors.
REQ-012 resp_err_o  out  1  misaligned access, qualified by resp_valid_o.
REQ-013 mem_req_o, mem_we_o  out  1 each  memory request, write enable.
REQ-014 mem_addr_o  out  8  word address = captured addr[9:2].
REQ-015 mem_wdata_o  out  32  full-word write data.
REQ-016 mem_ack_i  in  1  responder completion.
REQ-017 mem_rdata_i  in  32  read data, valid when mem_ack_i=1.

Function
REQ-018 SHALL capture addr, wdata, sizes on posedge when req_valid_i && req_ready_o; req_ready_o=1 only in IDLE.
REQ-019 FSM states: IDLE, RD, WR, RMW_RD, RMW_WR, ERR.
REQ-020 IDLE transitions on acceptance: load -> RD; `WORD` store -> WR; sub-word store -> RMW_RD; misaligned -> ERR; no load and no store -> stay IDLE, no response.
REQ-021 Misaligned: `WORD` with addr[1:0]!=0, or `HALFWORD` with addr[0]=1; ERR issues no memory request, gives resp_valid_o=1 and resp_err_o=1 next cycle, then returns to IDLE.
REQ-022 mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o SHALL be registered and held stable in RD/WR/RMW_RD/RMW_WR until mem_ack_i is sampled high.
REQ-023 mem_we_o=1 only in WR and RMW_WR.
REQ-024 One transfer completes per sampled ack; mem_req_o SHALL be low the cycle after the final ack.
REQ-025 RMW_RD on ack: merge the store lane into mem_rdata_i, latch the merged word, go to RMW_WR.
REQ-026 Store lanes: halfword addr[1]=0 -> bits[15:0], addr[1]=1 -> [31:16]; byte addr[1:0]=n -> bits[8n+7:8n] (little-endian).
REQ-027 Load lane selection follows the same lane mapping as stores, then sign-extends to 32 bits.
REQ-028 RD, WR and RMW_WR on ack -> IDLE; resp_valid_o pulses for exactly one cycle, the cycle after the ack.
REQ-029 Latency with zero-wait ack: load or word store, accept at cycle 0 -> mem_req_o cycle 1 -> resp_valid_o cycle 2; sub-word store -> resp_valid_o cycle 3.
REQ-030 Back-to-back: a new request may be accepted in the same cycle resp_valid_o=1.
REQ-031 mem_ack_i while mem_req_o=0 SHALL be ignored.
REQ-032 Inputs changing while req_ready_o=0 SHALL have no effect.

Reset
REQ-033 Asserting n_rst_i SHALL immediately force IDLE, req_ready_o=1, and every other output to 0, including mid-transaction; an outstanding memory transfer is abandoned.
REQ-034 The first acceptance SHALL occur on the first posedge after deassertion.

Structure
REQ-035 Size codes and FSM state encodings SHALL live in the shared header include.
REQ-036 Lane merge and load extract/sign-extend SHALL be one combinational sub-module, lsu_align.

Verification
REQ-037 Word store of 0xDEADBEEF to addr 0x10, ack immediate -> mem_addr_o=0x04, mem_we_o=1, mem_wdata_o=0xDEADBEEF, resp_valid_o at cycle 2, resp_err_o=0.
REQ-038 Byte store 0xAB to addr 0x13, memory word 0x11223344 -> read, then write 0xAB223344, resp_valid_o at cycle 3.
REQ-039 Halfword load from addr 0x06, memory word 0x8001_7FFF -> resp_data_o=0xFFFF8001; byte load from addr 0x04 -> 0xFFFFFFFF.
REQ-040 Word load from addr 0x02 -> no mem_req_o, resp_valid_o=1, resp_err_o=1, resp_data_o=0 next cycle.
REQ-041 Ack delayed 3 cycles -> mem_* held stable for 4 cycles, req_ready_o=0 throughout, single resp_valid_o pulse.
REQ-042 Assert n_rst_i in RMW_WR -> mem_req_o=0 immediately, IDLE; a spurious ack afterwards produces no response.
